// File: rtl/apb_req_master_pkg.sv
// rtl/apb_req_master_pkg.sv - shared types and constants for the request-to-APB bridge
//
// Contents:
//   apb_state_e             bridge FSM state (IDLE, SETUP, ACCESS)
//   DEFAULT_TIMEOUT_CYCLES  default ACCESS-phase cycle limit
//   TIMEOUT_CNT_WIDTH       width of the access timeout counter (covers 1..65535)
package apb_req_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;
    localparam int unsigned TIMEOUT_CNT_WIDTH      = 16;

endpackage

// File: rtl/apb_timeout_counter.sv
// rtl/apb_timeout_counter.sv - ACCESS-phase wait-state counter with limit detect
//
// Ports:
//   clk_i      clock
//   rst_ni     asynchronous active-low reset
//   clear_i    force the count to zero (held while the bridge is in SETUP)
//   en_i       count one stalled ACCESS cycle
//   limit_i    number of stalled ACCESS cycles that triggers expiry (>= 1)
//   expired_o  high in the stalled cycle that brings the count up to limit_i
module apb_timeout_counter
    import apb_req_master_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = TIMEOUT_CNT_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 en_i,
    input  logic [CNT_WIDTH-1:0] limit_i,
    output logic                 expired_o
);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic [CNT_WIDTH-1:0] limit_m1;

    assign limit_m1 = limit_i - {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // cnt_q holds the stalled cycles already seen, so the current stalled
    // cycle is the limit-th one when cnt_q equals limit-1.
    assign expired_o = en_i && (cnt_q == limit_m1);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/apb_req_master.sv
// rtl/apb_req_master.sv - request/grant/rvalid to APB3 initiator bridge
//
// Accepts one transfer at a time on a req/gnt port, runs it as an APB3
// SETUP + ACCESS sequence and returns a one-cycle rvalid_o with read data
// and error status. Define APB_REQ_MASTER_TIMEOUT_EN to abort ACCESS phases
// that stall for TIMEOUT_CYCLES cycles (reported as err_o=1, rdata_o=0).
//
// Ports:
//   clk_i, rst_ni                   clock, asynchronous active-low reset
//   req_i, addr_i, we_i, wdata_i    transfer request
//   gnt_o                           request accepted this cycle (IDLE only)
//   rvalid_o, rdata_o, err_o        response pulse, read data, error flag
//   paddr_o, pwdata_o, pwrite_o     APB address/data/direction
//   psel_o, penable_o               APB select/enable
//   prdata_i, pready_i, pslverr_i   APB read data, ready, slave error
module apb_req_master
    import apb_req_master_pkg::*;
#(
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned APB_DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      req_i,
    input  logic [APB_ADDR_WIDTH-1:0] addr_i,
    input  logic                      we_i,
    input  logic [APB_DATA_WIDTH-1:0] wdata_i,
    output logic                      gnt_o,
    output logic                      rvalid_o,
    output logic [APB_DATA_WIDTH-1:0] rdata_o,
    output logic                      err_o,
    output logic [APB_ADDR_WIDTH-1:0] paddr_o,
    output logic [APB_DATA_WIDTH-1:0] pwdata_o,
    output logic                      pwrite_o,
    output logic                      psel_o,
    output logic                      penable_o,
    input  logic [APB_DATA_WIDTH-1:0] prdata_i,
    input  logic                      pready_i,
    input  logic                      pslverr_i
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("apb_req_master: TIMEOUT_CYCLES must be within 1..65535");
    end

    apb_state_e                state_q;
    logic                      psel_q;
    logic                      penable_q;
    logic [APB_ADDR_WIDTH-1:0] paddr_q;
    logic [APB_DATA_WIDTH-1:0] pwdata_q;
    logic                      pwrite_q;
    logic                      rvalid_q;
    logic [APB_DATA_WIDTH-1:0] rdata_q;
    logic                      err_q;
    logic                      timeout_hit;

`ifdef APB_REQ_MASTER_TIMEOUT_EN
    localparam logic [TIMEOUT_CNT_WIDTH-1:0] TimeoutLimit = TIMEOUT_CNT_WIDTH'(TIMEOUT_CYCLES);

    apb_timeout_counter #(
        .CNT_WIDTH (TIMEOUT_CNT_WIDTH)
    ) u_timeout (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (state_q == ST_SETUP),
        .en_i      ((state_q == ST_ACCESS) && !pready_i),
        .limit_i   (TimeoutLimit),
        .expired_o (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    assign gnt_o = (state_q == ST_IDLE) && req_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pwrite_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            rvalid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_i) begin
                        paddr_q   <= addr_i;
                        pwdata_q  <= wdata_i;
                        pwrite_q  <= we_i;
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                        state_q   <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    // A ready slave wins over a timeout expiring in the same cycle.
                    if (pready_i) begin
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        rdata_q   <= pwrite_q ? '0 : prdata_i;
                        err_q     <= pslverr_i;
                        state_q   <= ST_IDLE;
                    end else if (timeout_hit) begin
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        rdata_q   <= '0;
                        err_q     <= 1'b1;
                        state_q   <= ST_IDLE;
                    end
                end
                default: begin
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    assign psel_o    = psel_q;
    assign penable_o = penable_q;
    assign paddr_o   = paddr_q;
    assign pwdata_o  = pwdata_q;
    assign pwrite_o  = pwrite_q;
    assign rvalid_o  = rvalid_q;
    assign rdata_o   = rdata_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_apb_req_master.sv
// tb/tb_apb_req_master.sv - scoreboard bench for apb_req_master
module tb_apb_req_master;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_i = 1'b0;
    logic [AW-1:0] addr_i = '0;
    logic          we_i = 1'b0;
    logic [DW-1:0] wdata_i = '0;
    logic          gnt_o, rvalid_o, err_o, pwrite_o, psel_o, penable_o;
    logic [DW-1:0] rdata_o, pwdata_o, prdata_i;
    logic [AW-1:0] paddr_o;
    logic          pready_i, pslverr_i;

    apb_req_master #(
        .APB_ADDR_WIDTH (AW),
        .APB_DATA_WIDTH (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .req_i     (req_i),
        .addr_i    (addr_i),
        .we_i      (we_i),
        .wdata_i   (wdata_i),
        .gnt_o     (gnt_o),
        .rvalid_o  (rvalid_o),
        .rdata_o   (rdata_o),
        .err_o     (err_o),
        .paddr_o   (paddr_o),
        .pwdata_o  (pwdata_o),
        .pwrite_o  (pwrite_o),
        .psel_o    (psel_o),
        .penable_o (penable_o),
        .prdata_i  (prdata_i),
        .pready_i  (pready_i),
        .pslverr_i (pslverr_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        int            waits;
        logic          slverr;
    } xfer_t;

    typedef struct {
        int            cycle;
        logic [DW-1:0] rdata;
        logic          err;
        logic [AW-1:0] addr;
    } exp_t;

    xfer_t slv_q[$];
    exp_t  exp_q[$];
    int    n_chk = 0;
    int    n_pass = 0;
    int    rvalid_cnt = 0;
    bit    stuck = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: response arrives 3 cycles after grant plus one per wait
    // state; writes return zero data; an abort comes after TO stalled
    // ACCESS cycles with err=1 and zero data.
    function automatic exp_t model(input xfer_t x, input int g, input bit timed_out);
        exp_t e;
        e.cycle = timed_out ? g + 2 + TO : g + 3 + x.waits;
        e.rdata = (x.we || timed_out) ? '0 : x.rdata;
        e.err   = timed_out ? 1'b1 : x.slverr;
        e.addr  = x.addr;
        return e;
    endfunction

    function automatic xfer_t rand_xfer();
        xfer_t x;
        x.we     = 1'($urandom_range(0, 1));
        x.addr   = $urandom & 32'hFFFF_FFFC;
        x.wdata  = $urandom;
        x.rdata  = $urandom;
        x.waits  = $urandom_range(0, 3);
        x.slverr = ($urandom_range(0, 7) == 0);
        return x;
    endfunction

    function automatic xfer_t mk(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                                 input logic [DW-1:0] rd, input int w, input logic se);
        xfer_t x;
        x.we = we; x.addr = a; x.wdata = wd; x.rdata = rd; x.waits = w; x.slverr = se;
        return x;
    endfunction

    task automatic issue(input xfer_t x, input bit keep_req, output int g);
        int t;
        t = 0;
        @(negedge clk);
        req_i = 1'b1; addr_i = x.addr; we_i = x.we; wdata_i = x.wdata;
        #1;
        while (!gnt_o && t < 200) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!gnt_o) begin
            chk("grant_wait", 0, 1);
            req_i = 1'b0;
            g = -1;
            return;
        end
        g = cyc;
        slv_q.push_back(x);
        if (!stuck) exp_q.push_back(model(x, g, 1'b0));
`ifdef APB_REQ_MASTER_TIMEOUT_EN
        else exp_q.push_back(model(x, g, 1'b1));
`endif
        @(posedge clk);
        #1;
        if (!keep_req) begin
            req_i = 1'b0; addr_i = $urandom; we_i = 1'($urandom_range(0, 1)); wdata_i = $urandom;
        end
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while (exp_q.size() > 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        #2;
        chk(name, exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_ctrl"}, {psel_o, penable_o, pwrite_o, rvalid_o, err_o, gnt_o}, 0);
        chk({name, "_paddr"}, paddr_o, 0);
        chk({name, "_pwdata"}, pwdata_o, 0);
        chk({name, "_rdata"}, rdata_o, 0);
    endtask

    task automatic mid_reset(input string name);
        int rv;
        rst_n = 1'b0;
        #1;
        check_reset_outputs(name);
        exp_q.delete();
        slv_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        rv = rvalid_cnt;
        repeat (12) @(negedge clk);
        #1;
        chk({name, "_no_rvalid_after"}, rvalid_cnt, rv);
    endtask

    // APB slave: one descriptor per SETUP, wait states then completion.
    initial begin
        xfer_t cur;
        int    wcnt;
        bit    active;
        active = 1'b0;
        wcnt = 0;
        pready_i = 1'b0; prdata_i = '0; pslverr_i = 1'b0;
        forever begin
            @(negedge clk);
            pready_i = 1'b0;
            prdata_i = $urandom;
            pslverr_i = 1'($urandom_range(0, 1));
            if (!rst_n || !psel_o) begin
                active = 1'b0;
            end else if (!penable_o) begin
                chk("gnt_low_in_setup", gnt_o, 0);
                if (slv_q.size() == 0) begin
                    chk("setup_unexpected", 1, 0);
                end else begin
                    cur = slv_q.pop_front();
                    active = 1'b1;
                    wcnt = cur.waits;
                    chk("setup_paddr", paddr_o, cur.addr);
                    chk("setup_pwrite", pwrite_o, cur.we);
                    if (cur.we) chk("setup_pwdata", pwdata_o, cur.wdata);
                end
            end else if (!stuck) begin
                if (!active) begin
                    chk("access_without_setup", 1, 0);
                end else if (wcnt > 0) begin
                    wcnt--;
                end else begin
                    pready_i = 1'b1;
                    prdata_i = cur.rdata;
                    pslverr_i = cur.slverr;
                    active = 1'b0;
                    chk("access_paddr", paddr_o, cur.addr);
                    chk("access_pwrite", pwrite_o, cur.we);
                    if (cur.we) chk("access_pwdata", pwdata_o, cur.wdata);
                end
            end
        end
    end

    // Response monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && rvalid_o) begin
                rvalid_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_rvalid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rvalid_cycle", cyc, e.cycle);
                    chk("rdata", rdata_o, e.rdata);
                    chk("err", err_o, e.err);
                    chk("paddr_hold", paddr_o, e.addr);
                end
            end
        end
    end

    initial begin
        int g, g_prev;
        xfer_t x;
        bit keep;

        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        issue(mk(1'b1, 32'h1A10_0000, 32'hCAFE_F00D, 32'hDEAD_BEEF, 0, 1'b0), 1'b0, g);
        drain("write_zero_wait");

        issue(mk(1'b0, 32'h1A10_1004, 32'h0, 32'h1234_5678, 2, 1'b0), 1'b0, g);
        drain("read_two_waits");

        issue(mk(1'b0, 32'h1A10_2000, 32'h0, 32'h5555_AAAA, 1, 1'b1), 1'b0, g);
        issue(mk(1'b1, 32'h1A10_2004, 32'h0BAD_F00D, 32'h0, 0, 1'b0), 1'b0, g);
        drain("slverr_then_ok");

        g_prev = -1;
        for (int i = 0; i < 4; i++) begin
            issue(mk(1'(i % 2), 32'h1A10_3000 + 32'(4 * i), $urandom, $urandom, 0, 1'b0), i < 3, g);
            if (i > 0) chk("b2b_grant_spacing", g - g_prev, 3);
            g_prev = g;
        end
        drain("back_to_back");

        for (int i = 0; i < 40; i++) begin
            x = rand_xfer();
            keep = (i < 39) && ($urandom_range(0, 1) == 1);
            issue(x, keep, g);
        end
        drain("random");

        stuck = 1'b1;
        issue(mk(1'b0, 32'h1A10_4000, 32'h0, 32'h7777_7777, 0, 1'b0), 1'b0, g);
`ifdef APB_REQ_MASTER_TIMEOUT_EN
        drain("timeout_abort");
        chk("timeout_psel_dropped", {psel_o, penable_o}, 0);
        stuck = 1'b0;
`else
        begin
            int rv;
            rv = rvalid_cnt;
            repeat (300) @(negedge clk);
            #1;
            chk("stuck_psel_held", {psel_o, penable_o}, 2'b11);
            chk("stuck_no_rvalid", rvalid_cnt, rv);
            stuck = 1'b0;
            @(negedge clk);
            #2;
            mid_reset("stuck_reset");
        end
`endif

        issue(mk(1'b0, 32'h1A10_5000, 32'h0, 32'h2468_ACE0, 2, 1'b0), 1'b0, g);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("in_access_before_reset", {psel_o, penable_o}, 2'b11);
        #1;
        mid_reset("access_reset");

        issue(mk(1'b0, 32'h1A10_6000, 32'h0, 32'h1357_9BDF, 1, 1'b0), 1'b0, g);
        drain("after_reset");
        chk("slave_queue_empty", slv_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
